// File: rtl/gpu_net_iface.sv
`timescale 1ns/1ps
// gpu_net_iface: per-GPU network interface.
// TX FIFO carries GPU flits to the router. RX FIFO carries router flits that
// are addressed to this node (flit[15:10] == GPU_ID[5:0]) to the GPU.
// Misaddressed router flits are consumed and counted in drop_count.
// Optional feature macro: NI_LOOPBACK_EN -- self-addressed TX flits are moved
// straight from the TX FIFO into the RX FIFO instead of going to the router.
module gpu_net_iface #(
  parameter int GPU_ID     = 19,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [15:0]      gpu_tx_data,
  input  logic             gpu_tx_valid,
  output logic             gpu_tx_ready,
  output logic [15:0]      gpu_rx_data,
  output logic             gpu_rx_valid,
  input  logic             gpu_rx_ready,
  output logic [15:0]      rtr_tx_data,
  output logic             rtr_tx_valid,
  input  logic             rtr_tx_ready,
  input  logic [15:0]      rtr_rx_data,
  input  logic             rtr_rx_valid,
  output logic             rtr_rx_ready,
  output logic [15:0]      drop_count,
  output logic [LVL_W-1:0] tx_level,
  output logic [LVL_W-1:0] rx_level
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [5:0]      MY_ID    = 6'(GPU_ID);

  logic [15:0]      tx_mem_q [FIFO_DEPTH];
  logic [15:0]      tx_mem_d [FIFO_DEPTH];
  logic [15:0]      rx_mem_q [FIFO_DEPTH];
  logic [15:0]      rx_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PTR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [LVL_W-1:0] tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic [15:0]      drop_q, drop_d;

  logic [15:0] tx_head, rx_head, rx_push_data;
  logic        tx_self, lb_take;
  logic        tx_push, tx_pop, rx_push, rx_pop, rx_hs, rx_match;

  // Handshake decode; ready/valid come only from registered levels and lb_take.
  always_comb begin
    tx_head = tx_mem_q[tx_rd_ptr_q];
    rx_head = rx_mem_q[rx_rd_ptr_q];
`ifdef NI_LOOPBACK_EN
    // A self-addressed head never goes to the router; it waits for RX space.
    tx_self = (tx_level_q != '0) && (tx_head[15:10] == MY_ID);
    lb_take = !ARESET && tx_self && (rx_level_q != FULL_LVL);
`else
    tx_self = 1'b0;
    lb_take = 1'b0;
`endif
    gpu_tx_ready = !ARESET && (tx_level_q != FULL_LVL);
    rtr_rx_ready = !ARESET && (rx_level_q != FULL_LVL) && !lb_take;
    rtr_tx_valid = !ARESET && (tx_level_q != '0) && !tx_self;
    gpu_rx_valid = !ARESET && (rx_level_q != '0);
    rtr_tx_data  = rtr_tx_valid ? tx_head : 16'h0000;
    gpu_rx_data  = gpu_rx_valid ? rx_head : 16'h0000;

    tx_push      = gpu_tx_valid && gpu_tx_ready;
    tx_pop       = (rtr_tx_valid && rtr_tx_ready) || lb_take;
    rx_hs        = rtr_rx_valid && rtr_rx_ready;
    rx_match     = (rtr_rx_data[15:10] == MY_ID);
    rx_push      = (rx_hs && rx_match) || lb_take;
    rx_push_data = lb_take ? tx_head : rtr_rx_data;
    rx_pop       = gpu_rx_valid && gpu_rx_ready;

    drop_count   = drop_q;
    tx_level     = tx_level_q;
    rx_level     = rx_level_q;
  end

  // Next-state for both FIFOs and the saturating drop counter.
  always_comb begin
    tx_mem_d    = tx_mem_q;
    rx_mem_d    = rx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    tx_level_d  = tx_level_q;
    rx_level_d  = rx_level_q;
    drop_d      = drop_q;

    if (tx_push) begin
      tx_mem_d[tx_wr_ptr_q] = gpu_tx_data;
      tx_wr_ptr_d           = tx_wr_ptr_q + PTR_W'(1);
    end
    if (tx_pop) tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(1);
    if (tx_push && !tx_pop) tx_level_d = tx_level_q + LVL_W'(1);
    if (!tx_push && tx_pop) tx_level_d = tx_level_q - LVL_W'(1);

    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = rx_push_data;
      rx_wr_ptr_d           = rx_wr_ptr_q + PTR_W'(1);
    end
    if (rx_pop) rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(1);
    if (rx_push && !rx_pop) rx_level_d = rx_level_q + LVL_W'(1);
    if (!rx_push && rx_pop) rx_level_d = rx_level_q - LVL_W'(1);

    if (rx_hs && !rx_match && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // State registers with synchronous reset; reset discards FIFO contents.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tx_mem_q    <= '{default: '0};
      rx_mem_q    <= '{default: '0};
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
      rx_level_q  <= '0;
      drop_q      <= '0;
    end else begin
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      tx_level_q  <= tx_level_d;
      rx_level_q  <= rx_level_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: tb/tb_gpu_net_iface.sv
`timescale 1ns/1ps
// Scoreboard bench for gpu_net_iface: accepted flits are queued as expected
// outputs, a monitor pops and compares on every output handshake, and a
// per-cycle checker compares levels, readies and the drop count to the model.
module tb_gpu_net_iface;
  localparam int GPU_ID = 19;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 3;

  logic             ACLK = 1'b0;
  logic             ARESET = 1'b1;
  logic [15:0]      gpu_tx_data = '0;
  logic             gpu_tx_valid = 1'b0;
  logic             gpu_tx_ready;
  logic [15:0]      gpu_rx_data;
  logic             gpu_rx_valid;
  logic             gpu_rx_ready = 1'b0;
  logic [15:0]      rtr_tx_data;
  logic             rtr_tx_valid;
  logic             rtr_tx_ready = 1'b0;
  logic [15:0]      rtr_rx_data = '0;
  logic             rtr_rx_valid = 1'b0;
  logic             rtr_rx_ready;
  logic [15:0]      drop_count;
  logic [LVL_W-1:0] tx_level;
  logic [LVL_W-1:0] rx_level;

  gpu_net_iface #(.GPU_ID(GPU_ID), .FIFO_DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .gpu_tx_data(gpu_tx_data), .gpu_tx_valid(gpu_tx_valid), .gpu_tx_ready(gpu_tx_ready),
    .gpu_rx_data(gpu_rx_data), .gpu_rx_valid(gpu_rx_valid), .gpu_rx_ready(gpu_rx_ready),
    .rtr_tx_data(rtr_tx_data), .rtr_tx_valid(rtr_tx_valid), .rtr_tx_ready(rtr_tx_ready),
    .rtr_rx_data(rtr_rx_data), .rtr_rx_valid(rtr_rx_valid), .rtr_rx_ready(rtr_rx_ready),
    .drop_count(drop_count), .tx_level(tx_level), .rx_level(rx_level)
  );

  always #5 ACLK = ~ACLK;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_tx[$];
  logic [15:0] exp_rx[$];
  int          drop_exp = 0;
  bit          chk_en = 1'b0;
  bit          skip_lvl = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_local(input logic [15:0] f);
    return f[15:10] == 6'(GPU_ID);
  endfunction

  // Stimulus side: every accepted input flit becomes an expected output.
  always @(negedge ACLK) begin
    if (ARESET) begin
      exp_tx.delete();
      exp_rx.delete();
      drop_exp = 0;
    end else begin
      if (gpu_tx_valid && gpu_tx_ready) begin
`ifdef NI_LOOPBACK_EN
        if (is_local(gpu_tx_data)) exp_rx.push_back(gpu_tx_data);
        else
`endif
        exp_tx.push_back(gpu_tx_data);
      end
      if (rtr_rx_valid && rtr_rx_ready) begin
        if (is_local(rtr_rx_data)) exp_rx.push_back(rtr_rx_data);
        else if (drop_exp < 65535) drop_exp++;
      end
    end
  end

  // Output monitor: pop and compare on each output handshake.
  always @(negedge ACLK) begin
    logic [15:0] e;
    if (rtr_tx_valid === 1'b1 && rtr_tx_ready) begin
      if (exp_tx.size() == 0) check("rtr_tx_unexpected", {16'h0, rtr_tx_data}, 32'hFFFF_FFFF);
      else begin
        e = exp_tx.pop_front();
        check("rtr_tx_data", {16'h0, rtr_tx_data}, {16'h0, e});
      end
    end
    if (gpu_rx_valid === 1'b1 && gpu_rx_ready) begin
      if (exp_rx.size() == 0) check("gpu_rx_unexpected", {16'h0, gpu_rx_data}, 32'hFFFF_FFFF);
      else begin
        e = exp_rx.pop_front();
        check("gpu_rx_data", {16'h0, gpu_rx_data}, {16'h0, e});
      end
    end
  end

  // Per-cycle state checker against the queue-occupancy model.
  always @(posedge ACLK) begin
    #2;
    if (chk_en && !skip_lvl) begin
      check("tx_level", 32'(tx_level), 32'(exp_tx.size()));
      check("rx_level", 32'(rx_level), 32'(exp_rx.size()));
      check("gpu_tx_ready", 32'(gpu_tx_ready), 32'(!ARESET && exp_tx.size() != DEPTH));
      check("rtr_rx_ready", 32'(rtr_rx_ready), 32'(!ARESET && exp_rx.size() != DEPTH));
      check("rtr_tx_valid", 32'(rtr_tx_valid), 32'(!ARESET && exp_tx.size() != 0));
      check("gpu_rx_valid", 32'(gpu_rx_valid), 32'(!ARESET && exp_rx.size() != 0));
      if (!rtr_tx_valid) check("rtr_tx_data_idle", 32'(rtr_tx_data), 32'h0);
      if (!gpu_rx_valid) check("gpu_rx_data_idle", 32'(gpu_rx_data), 32'h0);
      check("drop_count", 32'(drop_count), 32'(drop_exp));
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic gpu_send(input logic [15:0] d);
    bit ok = 1'b0;
    gpu_tx_data  = d;
    gpu_tx_valid = 1'b1;
    for (int n = 0; n < 64 && !ok; n++) begin
      ok = gpu_tx_ready;
      tick();
    end
    gpu_tx_valid = 1'b0;
    check("gpu_send_accept", 32'(ok), 32'h1);
  endtask

  task automatic rtr_send(input logic [15:0] d);
    bit ok = 1'b0;
    rtr_rx_data  = d;
    rtr_rx_valid = 1'b1;
    for (int n = 0; n < 64 && !ok; n++) begin
      ok = rtr_rx_ready;
      tick();
    end
    rtr_rx_valid = 1'b0;
    check("rtr_send_accept", 32'(ok), 32'h1);
  endtask

  initial begin
    bit ok;
    logic [5:0] dst;
    ARESET = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    ARESET = 1'b0;
    #1;
    check("rst_gpu_tx_ready", 32'(gpu_tx_ready), 32'h1);
    check("rst_rtr_rx_ready", 32'(rtr_rx_ready), 32'h1);
    check("rst_valids", {30'h0, rtr_tx_valid, gpu_rx_valid}, 32'h0);
    check("rst_drop", 32'(drop_count), 32'h0);
    check("rst_levels", {26'h0, tx_level, rx_level}, 32'h0);
    tick();

    // single flit to the router, one cycle latency
    rtr_tx_ready = 1'b1;
    gpu_send(16'h5123);
    check("pass_valid", 32'(rtr_tx_valid), 32'h1);
    check("pass_data", 32'(rtr_tx_data), 32'h5123);
    tick();
    check("pass_drain", 32'(tx_level), 32'h0);

    // TX full back-pressure, fifth flit held
    rtr_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) gpu_send(16'h5200 + 16'(i));
    check("full_ready", 32'(gpu_tx_ready), 32'h0);
    check("full_level", 32'(tx_level), 32'h4);
    gpu_tx_data  = 16'h5204;
    gpu_tx_valid = 1'b1;
    tick(); tick();
    check("full_held", 32'(tx_level), 32'h4);
    rtr_tx_ready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 16 && !ok; n++) begin
      ok = gpu_tx_ready;
      tick();
    end
    gpu_tx_valid = 1'b0;
    check("full_fifth_accept", 32'(ok), 32'h1);
    repeat (8) tick();

    // destination filtering
    gpu_rx_ready = 1'b1;
    rtr_send(16'h4C7B);
    check("filt_valid", 32'(gpu_rx_valid), 32'h1);
    check("filt_data", 32'(gpu_rx_data), 32'h4C7B);
    rtr_send(16'h5000);
    repeat (3) tick();
    check("filt_drop", 32'(drop_count), 32'h1);
    check("filt_rx_empty", 32'(rx_level), 32'h0);

    // simultaneous RX push/pop at level 2
    gpu_rx_ready = 1'b0;
    rtr_send(16'h4C00);
    rtr_send(16'h4C01);
    check("steady_start", 32'(rx_level), 32'h2);
    gpu_rx_ready = 1'b1;
    rtr_rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rtr_rx_data = 16'h4C10 + 16'(i);
      tick();
      check("steady_level", 32'(rx_level), 32'h2);
    end
    rtr_rx_valid = 1'b0;
    repeat (4) tick();

    // self-addressed flit from the GPU
    rtr_tx_ready = 1'b1;
`ifdef NI_LOOPBACK_EN
    gpu_rx_ready = 1'b0;
    skip_lvl = 1'b1;
    gpu_send(16'h4C01);
    check("lb_rtr_rx_ready", 32'(rtr_rx_ready), 32'h0);
    check("lb_rtr_tx_valid", 32'(rtr_tx_valid), 32'h0);
    tick();
    check("lb_rx_valid", 32'(gpu_rx_valid), 32'h1);
    check("lb_rx_data", 32'(gpu_rx_data), 32'h4C01);
    check("lb_tx_empty", 32'(tx_level), 32'h0);
    gpu_rx_ready = 1'b1;
    tick();
    skip_lvl = 1'b0;
`else
    gpu_send(16'h4C01);
    check("self_rtr_valid", 32'(rtr_tx_valid), 32'h1);
    check("self_rtr_data", 32'(rtr_tx_data), 32'h4C01);
`endif
    repeat (3) tick();

    // randomized traffic in both directions
    for (int c = 0; c < 3000; c++) begin
      dst = ($urandom_range(0, 1) == 0) ? 6'd20 : 6'($urandom);
`ifdef NI_LOOPBACK_EN
      if (dst == 6'(GPU_ID)) dst = 6'd21;
`endif
      gpu_tx_data  = {dst, 10'($urandom)};
      gpu_tx_valid = 1'($urandom);
      dst = ($urandom_range(0, 1) == 0) ? 6'(GPU_ID) : 6'($urandom);
      rtr_rx_data  = {dst, 10'($urandom)};
      rtr_rx_valid = 1'($urandom);
      rtr_tx_ready = ($urandom_range(0, 3) != 0);
      gpu_rx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // reset in the middle of traffic
    gpu_tx_valid = 1'b1;
    rtr_rx_valid = 1'b1;
    ARESET = 1'b1;
    tick(); tick();
    check("mid_rst_levels", {26'h0, tx_level, rx_level}, 32'h0);
    check("mid_rst_drop", 32'(drop_count), 32'h0);
    ARESET = 1'b0;
    gpu_tx_valid = 1'b0;
    rtr_rx_valid = 1'b0;
    tick();

    // drop counter saturation
    gpu_rx_ready = 1'b1;
    rtr_rx_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      rtr_rx_data = {6'd20, 10'(i)};
      tick();
    end
    rtr_rx_valid = 1'b0;
    tick();
    check("drop_saturate", 32'(drop_count), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
